// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared opcode, state, selector and load-strobe definitions for the TD4 sequencer
package td4_pkg;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_DECODE = 2'b10,
        ST_EXEC   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_IN   = 2'b10,
        SEL_ZERO = 2'b11
    } sel_t;

    typedef enum logic [2:0] {
        TGT_A    = 3'd0,
        TGT_B    = 3'd1,
        TGT_OUT  = 3'd2,
        TGT_PC   = 3'd3,
        TGT_NONE = 3'd4
    } target_t;

    typedef struct packed {
        target_t target;
        sel_t    sel;
        logic    cond;
        logic    illegal;
    } ctl_t;

    // Active-low strobe vector with only the target's bit pulled low.
    function automatic logic [3:0] load_strobe(input target_t t);
        logic [3:0] v;
        v = 4'b1111;
        case (t)
            TGT_A:   v[LD_A]   = 1'b0;
            TGT_B:   v[LD_B]   = 1'b0;
            TGT_OUT: v[LD_OUT] = 1'b0;
            TGT_PC:  v[LD_PC]  = 1'b0;
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program ROM fetch handshake between sequencer and ROM
interface instr_sequencer_if;
    logic       ROM_REQ;
    logic [3:0] ROM_ADDR;
    logic       ROM_ACK;
    logic [7:0] ROM_DATA;

    modport master (
        output ROM_REQ,
        output ROM_ADDR,
        input  ROM_ACK,
        input  ROM_DATA
    );

    modport slave (
        input  ROM_REQ,
        input  ROM_ADDR,
        output ROM_ACK,
        output ROM_DATA
    );
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode to control mapping
module instr_decode
    import td4_pkg::*;
(
    input  logic [3:0] opcode,
    output ctl_t       ctl
);

    always_comb begin
        ctl.target  = TGT_NONE;
        ctl.sel     = SEL_ZERO;
        ctl.cond    = 1'b0;
        ctl.illegal = 1'b0;
        case (opcode)
            OP_ADD_A_IM: begin ctl.target = TGT_A;   ctl.sel = SEL_A;    end
            OP_ADD_B_IM: begin ctl.target = TGT_B;   ctl.sel = SEL_B;    end
            OP_MOV_A_IM: begin ctl.target = TGT_A;   ctl.sel = SEL_ZERO; end
            OP_MOV_B_IM: begin ctl.target = TGT_B;   ctl.sel = SEL_ZERO; end
            OP_MOV_A_B:  begin ctl.target = TGT_A;   ctl.sel = SEL_B;    end
            OP_MOV_B_A:  begin ctl.target = TGT_B;   ctl.sel = SEL_A;    end
            OP_IN_A:     begin ctl.target = TGT_A;   ctl.sel = SEL_IN;   end
            OP_IN_B:     begin ctl.target = TGT_B;   ctl.sel = SEL_IN;   end
            OP_OUT_B:    begin ctl.target = TGT_OUT; ctl.sel = SEL_B;    end
            OP_OUT_IM:   begin ctl.target = TGT_OUT; ctl.sel = SEL_ZERO; end
            OP_JMP:      begin ctl.target = TGT_PC;  ctl.sel = SEL_ZERO; end
            OP_JNC: begin
                ctl.target = TGT_PC;
                ctl.sel    = SEL_ZERO;
                ctl.cond   = 1'b1;
            end
            // Undefined opcodes run as a NOP that only flags itself.
            default: ctl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - TD4 fetch/decode/execute sequencer driving load strobes and selector
module instr_sequencer
    import td4_pkg::*;
(
    input  logic               CLK,
    input  logic               CLR,
    instr_sequencer_if.master  rom,
    input  logic [3:0]         PC_VAL,
    input  logic               CFLAG_n,
    output logic [3:0]         LOAD_n,
    output logic [1:0]         SEL,
    output logic [3:0]         IM,
    output logic               PC_EN,
    output logic               FLAG_EN,
    output logic               ILLEGAL
);

    state_t     state;
    state_t     state_nx;
    logic       first_q;
    logic [3:0] addr_q;
    logic [7:0] ir_q;
    ctl_t       ctl_q;
    ctl_t       dec_ctl;

    instr_decode u_decode (
        .opcode (ir_q[7:4]),
        .ctl    (dec_ctl)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // first_q marks the first FETCH cycle, when PC_VAL is taken as the fetch address.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            first_q       <= 1'b0;
            addr_q        <= 4'b0000;
            ir_q          <= 8'h00;
            ctl_q.target  <= TGT_NONE;
            ctl_q.sel     <= SEL_ZERO;
            ctl_q.cond    <= 1'b0;
            ctl_q.illegal <= 1'b0;
        end else begin
            first_q <= (state_nx == ST_FETCH) && (state != ST_FETCH);
            if (state == ST_FETCH && first_q) begin
                addr_q <= PC_VAL;
            end
            if (state == ST_FETCH && rom.ROM_ACK) begin
                ir_q <= rom.ROM_DATA;
            end
            if (state == ST_DECODE) begin
                ctl_q <= dec_ctl;
            end
        end
    end

    assign rom.ROM_ADDR = (state == ST_FETCH && first_q) ? PC_VAL : addr_q;
    assign IM           = ir_q[3:0];

    always_comb begin
        state_nx    = state;
        rom.ROM_REQ = 1'b0;
        LOAD_n      = 4'b1111;
        SEL         = SEL_ZERO;
        PC_EN       = 1'b0;
        FLAG_EN     = 1'b0;
        ILLEGAL     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                rom.ROM_REQ = 1'b1;
                if (rom.ROM_ACK) begin
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                SEL      = dec_ctl.sel;
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                SEL     = ctl_q.sel;
                FLAG_EN = 1'b1;
                ILLEGAL = ctl_q.illegal;
                // A JNC with carry set (CFLAG_n low) falls through to the next instruction.
                if (ctl_q.cond && !CFLAG_n) begin
                    PC_EN = 1'b1;
                end else begin
                    LOAD_n = load_strobe(ctl_q.target);
                    PC_EN  = (ctl_q.target != TGT_PC);
                end
                state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The port CLK, input, width 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 The port CLR, input, width 1, SHALL be the asynchronous, active-high reset.
REQ-003 The port ROM_REQ, output, width 1, SHALL be the instruction-fetch request to program ROM.
REQ-004 The port ROM_ADDR, output, width 4, SHALL be the fetch address; it SHALL equal PC_VAL sampled on entry to FETCH.
REQ-005 The port ROM_ACK, input, width 1, SHALL indicate that ROM_DATA is valid this cycle.
REQ-006 The port ROM_DATA, input, width 8, SHALL carry the instruction word: [7:4] opcode, [3:0] immediate.
REQ-007 The port PC_VAL, input, width 4, SHALL carry the current program counter value.
REQ-008 The port CFLAG_n, input, width 1, SHALL carry the flag-register output in negative logic (0 = carry set).
REQ-009 The port LOAD_n, output, width 4, SHALL be the active-low load strobes: [0] A, [1] B, [2] OUT port, [3] PC.
REQ-010 The port SEL, output, width 2, SHALL drive the data-selector source: 00 A, 01 B, 10 IN port, 11 zero.
REQ-011 The port IM, output, width 4, SHALL carry the latched immediate.
REQ-012 The port PC_EN, output, width 1, SHALL be the active-high PC increment strobe.
REQ-013 The port FLAG_EN, output, width 1, SHALL be the active-high flag-capture strobe.
REQ-014 The port ILLEGAL, output, width 1, SHALL pulse for one cycle on an undefined opcode.

Function
REQ-015 The FSM SHALL have four states: IDLE, FETCH, DECODE, EXEC.
REQ-016 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-017 In FETCH, ROM_REQ SHALL be 1 and ROM_ADDR SHALL be held stable until ROM_ACK=1.
REQ-018 ROM_DATA SHALL be captured in the cycle ROM_ACK=1, ROM_REQ SHALL drop the next cycle, and the FSM SHALL move to DECODE.
REQ-019 ROM_ACK SHALL be ignored outside FETCH.
REQ-020 DECODE SHALL register opcode-derived controls for one cycle; SEL and IM SHALL be valid from DECODE through EXEC.
REQ-021 EXEC SHALL last one cycle; the selected LOAD_n bit, PC_EN and FLAG_EN SHALL assert only in EXEC; the FSM SHALL then return to FETCH.
REQ-022 Minimum instruction latency SHALL be 3 cycles (ROM_ACK in the first FETCH cycle); each ROM wait cycle SHALL add exactly 1 cycle.
REQ-023 Opcode decode table (opcode: load target, SEL):
- 0000 ADD A,Im: A, 00
- 0101 ADD B,Im: B, 01
- 0011 MOV A,Im: A, 11
- 0111 MOV B,Im: B, 11
- 0001 MOV A,B: A, 01
- 0100 MOV B,A: B, 00
- 0010 IN A: A, 10
- 0110 IN B: B, 10
- 1001 OUT B: OUT, 01
- 1011 OUT Im: OUT, 11
- 1111 JMP: PC, 11
- 1110 JNC: PC, 11
REQ-024 JNC SHALL be taken only when CFLAG_n=1 (sampled in EXEC); when taken, LOAD_n[3]=0 and PC_EN=0; otherwise LOAD_n=1111 and PC_EN=1.
REQ-025 For every instruction other than taken JMP/JNC, PC_EN SHALL be 1 in EXEC, and at most one LOAD_n bit SHALL be low in any cycle.
REQ-026 FLAG_EN SHALL be 1 in EXEC for every instruction.
REQ-027 Opcodes 1000, 1010, 1100 and 1101 SHALL execute as a NOP (LOAD_n=1111, PC_EN=1, FLAG_EN=1) with ILLEGAL=1 in EXEC.

Reset
REQ-028 While CLR=1, the state SHALL be IDLE and outputs SHALL be: ROM_REQ=0, ROM_ADDR=0000, LOAD_n=1111, SEL=11, IM=0000, PC_EN=0, FLAG_EN=0, ILLEGAL=0.
REQ-029 Reset asserted in any state, including mid-FETCH, SHALL abort the instruction immediately with no strobe issued; after release, the fetch SHALL restart from IDLE.

Structure
REQ-030 A shared package td4_pkg SHALL hold the opcode constants, the state enum, the SEL encodings and the LOAD_n bit indices.
REQ-031 Opcode-to-control mapping SHALL be a combinational sub-module instr_decode; the FSM and registers SHALL remain in instr_sequencer.

Verification
REQ-032 Scenario: ROM_DATA=0011_0101 with ACK in the first FETCH cycle -> in EXEC, LOAD_n=1110, SEL=11, IM=0101, PC_EN=1; 3 cycles total.
REQ-033 Scenario: ROM_DATA=1110_1010 with CFLAG_n=1 -> LOAD_n=0111, PC_EN=0; with CFLAG_n=0 -> LOAD_n=1111, PC_EN=1.
REQ-034 Scenario: ACK delayed 4 cycles -> ROM_REQ=1 and ROM_ADDR stable for 5 cycles; instruction takes 7 cycles.
REQ-035 Scenario: CLR pulsed mid-FETCH -> ROM_REQ=0 and LOAD_n=1111 immediately; after release, IDLE lasts 1 cycle, then FETCH.
REQ-036 Scenario: ROM_DATA=1100_0000 -> ILLEGAL=1 for one cycle, LOAD_n=1111, PC_EN=1.
REQ-037 Scenario: ROM_DATA=1001_0000 -> LOAD_n=1011, SEL=01; a spurious ROM_ACK during EXEC has no effect.
